fwrisc_csr_rmw: RTL and testbench
=================================

// Module: fwrisc_csr_rmw
// PURPOSE
//  Sequencer for CSRRW/CSRRS/CSRRC: the read/modify/write client of the register file.
//  Accepts a pre-decoded CSR request and reads the old CSR value on the RB port.
//  Writes the new CSR value, then the old value to rd, on the shared write port.
//  Sits between the decoder/execute stage and fwrisc_regfile; owns RB and RD ports while busy.
// PARAMETERS
//  ENABLE_RO_CHECK  1  1: reject writes to read-only CSR indices (flag illegal, no writes)
// PORTS
//  clock       in   1   core clock
//  reset       in   1   asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   high in IDLE only; accept = req_valid && req_ready
//  req_op      in   2   01=RW, 10=RS (set bits), 11=RC (clear bits), 00=illegal
//  req_csr     in   6   regfile CSR index, 6'h20..6'h3F
//  req_rd      in   5   destination GPR; 0 = no rd write
//  req_src     in   32  rs1 value or zero-extended zimm
//  req_src_x0  in   1   source is x0/zimm==0 (RS/RC then perform no CSR write)
//  busy        out  1   high in READ/WCSR/WRD; core muxes RB/RD ports to this block
//  rb_raddr    out  6   regfile RB read address
//  rb_rdata    in   32  regfile RB read data (combinational)
//  rd_waddr    out  6   regfile write address
//  rd_wdata    out  32  regfile write data
//  rd_wen      out  1   regfile write enable
//  done        out  1   one-cycle completion pulse
//  illegal     out  1   valid with done; op illegal, nothing written
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, busy=0, rb_raddr=0, rd_waddr=0, rd_wdata=0, rd_wen=0, done=0, illegal=0.
//  State machine: IDLE -> READ -> WCSR -> WRD -> RESP -> IDLE. Each state lasts 1 cycle.
//  IDLE: on accept, latch op/csr/rd/src/src_x0 and go to READ.
//  READ: rb_raddr=csr_q; latch old_q=rb_rdata at end of cycle.
//   Compute wr_csr = (op==RW) || !src_x0_q.
//   Compute illegal_q = (op==00) || (ENABLE_RO_CHECK && wr_csr && csr_q in CSR_RO_LO..CSR_RO_HI).
//   If illegal_q, go straight to RESP.
//  WCSR: if wr_csr: rd_wen=1, rd_waddr=csr_q, rd_wdata=new.
//   new = RW: src; RS: old|src; RC: old&~src. Full 32-bit bitwise, no arithmetic.
//   If !wr_csr, no write; the cycle is still spent (fixed latency).
//  WRD: if rd_q!=0: rd_wen=1, rd_waddr={1'b0,rd_q}, rd_wdata=old_q; else no write.
//  RESP: done=1, illegal=illegal_q; go to IDLE. req_ready returns to 1 the cycle after RESP.
//  Latency: accept at edge N -> done high in cycle N+4, fixed for legal ops.
//   Illegal ops: done in cycle N+2.
//  rd_wen is never high outside WCSR/WRD. At most one write per cycle.
//  CSR write precedes rd write, so old value is read before any modification.
//  rd write of the old value is unconditional of wr_csr: CSRRS rd,csr,x0 still returns the old value.
//  req_valid while busy is ignored (req_ready=0); the request must be held by the source.
//  Reset mid-operation: immediate return to IDLE, all outputs to reset values.
//   A CSR write already committed in WCSR stays committed; the rd write is dropped.
//  Counter CSRs keep counting while READ..WCSR; the value written in WCSR is based on old_q from READ.
// STRUCTURE
//  Package fwrisc_csr_rmw_pkg holds:
//   - typedef enum logic[1:0] csr_op_e {CSR_OP_ILL, CSR_OP_RW, CSR_OP_RS, CSR_OP_RC}
//   - typedef enum state_e {IDLE, READ, WCSR, WRD, RESP}
//   - localparams CSR_RO_LO=6'h20, CSR_RO_HI=6'h27
//  Single module, no sub-modules. The new-value function may be a package function csr_apply(op, old, src).
// TESTING
//  Test 1: preload CSR 6'h30=32'h0000_00F0. RW csr=30 rd=5 src=32'h1234_5678.
//   Expect WCSR write 30<=32'h12345678, WRD write 5<=32'hF0, done at N+4, illegal=0.
//  Test 2: CSR 30=32'hF0. RS src=32'h0F rd=0. Expect write 30<=32'hFF, no rd write.
//   Then RC src=32'hF0. Expect 30<=32'h0F.
//  Test 3: RS with src_x0=1 rd=7, CSR 30=32'hAA. Expect no CSR write, 7<=32'hAA.
//  Test 4: RW csr=6'h21 (read-only). Expect zero rd_wen cycles, done at N+2 with illegal=1.
//   Also op=00 gives the same result.
//  Test 5: assert reset during WCSR. Expect all outputs 0 within the same cycle, no WRD write.
//   A new request is accepted immediately after reset release.
//  Test 6: back-to-back requests with req_valid held high.
//   Expect accepts 5 cycles apart and req_ready low throughout READ..RESP.

Source files
------------

// File: rtl/fwrisc_csr_rmw_pkg.sv
// Shared types and constants for the CSR read/modify/write sequencer.
// The new-value rule lives here so the sequencer stays a plain state machine.
package fwrisc_csr_rmw_pkg;

    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WCSR = 3'd2,
        WRD  = 3'd3,
        RESP = 3'd4
    } state_e;

    // Inclusive range of read-only CSR indices in the regfile CSR window
    localparam logic [5:0] CSR_RO_LO = 6'h20;
    localparam logic [5:0] CSR_RO_HI = 6'h27;

    function automatic logic [31:0] csr_apply(
        input csr_op_e     op,
        input logic [31:0] old_val,
        input logic [31:0] src
    );
        logic [31:0] result;
        case (op)
            CSR_OP_RW: result = src;
            CSR_OP_RS: result = old_val | src;
            CSR_OP_RC: result = old_val & ~src;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/fwrisc_csr_rmw.sv
// CSRRW/CSRRS/CSRRC sequencer: reads the old CSR on RB, writes the new CSR value,
// then writes the old value to rd over the shared regfile write port.
module fwrisc_csr_rmw
    import fwrisc_csr_rmw_pkg::*;
#(
    parameter bit ENABLE_RO_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_csr,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_src,
    input  logic        req_src_x0,
    output logic        busy,
    output logic [5:0]  rb_raddr,
    input  logic [31:0] rb_rdata,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
    output logic        done,
    output logic        illegal
);

    state_e      state, state_nxt;
    csr_op_e     op_q;
    logic [5:0]  csr_q;
    logic [4:0]  rd_q;
    logic [31:0] src_q;
    logic        src_x0_q;
    logic [31:0] old_q;
    logic        illegal_q;

    logic accept;
    logic wr_csr;
    logic csr_is_ro;
    logic illegal_c;

    assign accept    = req_valid && req_ready;
    // RS/RC with an x0/zero source must not touch the CSR at all
    assign wr_csr    = (op_q == CSR_OP_RW) || !src_x0_q;
    assign csr_is_ro = (csr_q >= CSR_RO_LO) && (csr_q <= CSR_RO_HI);
    assign illegal_c = (op_q == CSR_OP_ILL) || (ENABLE_RO_CHECK && wr_csr && csr_is_ro);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= CSR_OP_ILL;
            csr_q     <= '0;
            rd_q      <= '0;
            src_q     <= '0;
            src_x0_q  <= 1'b0;
            old_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= csr_op_e'(req_op);
                csr_q    <= req_csr;
                rd_q     <= req_rd;
                src_q    <= req_src;
                src_x0_q <= req_src_x0;
            end
            if (state == READ) begin
                old_q     <= rb_rdata;
                illegal_q <= illegal_c;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        rb_raddr  = '0;
        rd_waddr  = '0;
        rd_wdata  = '0;
        rd_wen    = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = READ;
            end
            READ: begin
                busy      = 1'b1;
                rb_raddr  = csr_q;
                state_nxt = illegal_c ? RESP : WCSR;
            end
            WCSR: begin
                busy = 1'b1;
                if (wr_csr) begin
                    rd_wen   = 1'b1;
                    rd_waddr = csr_q;
                    rd_wdata = csr_apply(op_q, old_q, src_q);
                end
                state_nxt = WRD;
            end
            WRD: begin
                busy = 1'b1;
                if (rd_q != '0) begin
                    rd_wen   = 1'b1;
                    rd_waddr = {1'b0, rd_q};
                    rd_wdata = old_q;
                end
                state_nxt = RESP;
            end
            RESP: begin
                done      = 1'b1;
                illegal   = illegal_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fwrisc_csr_rmw.sv
// Self-checking bench for fwrisc_csr_rmw: a regfile stand-in plus a rule-based
// model of which writes each CSR instruction must produce, and when done fires.
module tb_fwrisc_csr_rmw;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_csr;
    logic [4:0]  req_rd;
    logic [31:0] req_src;
    logic        req_src_x0;
    logic        busy;
    logic [5:0]  rb_raddr;
    logic [31:0] rb_rdata;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic        done;
    logic        illegal;

    int total = 0;
    int bad   = 0;
    int last_tries;

    always #5 clock = ~clock;

    fwrisc_csr_rmw #(.ENABLE_RO_CHECK(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_csr    (req_csr),
        .req_rd     (req_rd),
        .req_src    (req_src),
        .req_src_x0 (req_src_x0),
        .busy       (busy),
        .rb_raddr   (rb_raddr),
        .rb_rdata   (rb_rdata),
        .rd_waddr   (rd_waddr),
        .rd_wdata   (rd_wdata),
        .rd_wen     (rd_wen),
        .done       (done),
        .illegal    (illegal)
    );

    // Regfile stand-in: combinational RB read, one write port shared with preload
    logic [31:0] regs [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign rb_rdata = regs[rb_raddr];

    always @(posedge clock) begin
        if (rd_wen)      regs[rd_waddr] <= rd_wdata;
        else if (pre_en) regs[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clock);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] csr,
                          input logic [4:0] rd, input logic [31:0] src, input logic src_x0);
        logic [31:0] old_v, new_v;
        logic [5:0]  exp_a[$], got_a[$];
        logic [31:0] exp_d[$], got_d[$];
        bit          ill, wr, accepted;
        int          lat;

        // Reference: which writes the instruction must cause, from the ISA rules
        old_v = regs[csr];
        wr    = (op == 2'b01) || !src_x0;
        ill   = (op == 2'b00) || (wr && csr >= 6'h20 && csr <= 6'h27);
        case (op)
            2'b01:   new_v = src;
            2'b10:   new_v = old_v | src;
            2'b11:   new_v = old_v & ~src;
            default: new_v = old_v;
        endcase
        if (!ill) begin
            if (wr) begin exp_a.push_back(csr); exp_d.push_back(new_v); end
            if (rd != 0) begin exp_a.push_back({1'b0, rd}); exp_d.push_back(old_v); end
        end

        @(negedge clock);
        req_valid = 1'b1; req_op = op; req_csr = csr; req_rd = rd;
        req_src = src; req_src_x0 = src_x0;
        accepted = 1'b0;
        last_tries = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            if (req_ready) begin
                accepted = 1'b1;
                @(posedge clock);
            end else begin
                last_tries++;
                @(posedge clock);
                @(negedge clock);
            end
        end
        #1 req_valid = 1'b0;
        check({name, "_accept"}, 32'(accepted), 32'd1);

        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clock);
            if (k == 1) check({name, "_ready_low"}, 32'(req_ready), 32'd0);
            if (rd_wen) begin got_a.push_back(rd_waddr); got_d.push_back(rd_wdata); end
            if (done) begin
                lat = k;
                check({name, "_illegal"}, 32'(illegal), 32'(ill));
            end
        end
        check({name, "_latency"}, lat, ill ? 2 : 4);
        check({name, "_nwrites"}, got_a.size(), exp_a.size());
        for (int j = 0; j < exp_a.size() && j < got_a.size(); j++) begin
            check({name, "_waddr"}, 32'(got_a[j]), 32'(exp_a[j]));
            check({name, "_wdata"}, got_d[j], exp_d[j]);
        end
    endtask

    initial begin
        int acc_at[$];
        logic [1:0]  r_op;
        logic [5:0]  r_csr;
        logic [4:0]  r_rd;
        logic        r_x0;
        logic [31:0] r_src;

        reset = 1'b1;
        req_valid = 1'b0; req_op = '0; req_csr = '0; req_rd = '0;
        req_src = '0; req_src_x0 = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wen", 32'(rd_wen), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_raddr", 32'(rb_raddr), 32'd0);
        check("rst_waddr", 32'(rd_waddr), 32'd0);
        check("rst_wdata", rd_wdata, 32'd0);
        reset = 1'b0;

        // Directed cases
        preload(6'h30, 32'h0000_00F0);
        run_op("t1_rw", 2'b01, 6'h30, 5'd5, 32'h1234_5678, 1'b0);
        preload(6'h30, 32'h0000_00F0);
        run_op("t2_rs", 2'b10, 6'h30, 5'd0, 32'h0000_000F, 1'b0);
        run_op("t2_rc", 2'b11, 6'h30, 5'd0, 32'h0000_00F0, 1'b0);
        check("t2_final", regs[6'h30], 32'h0000_000F);
        preload(6'h30, 32'h0000_00AA);
        run_op("t3_rs_x0", 2'b10, 6'h30, 5'd7, 32'h0, 1'b1);
        check("t3_csr_kept", regs[6'h30], 32'h0000_00AA);
        run_op("t4_ro", 2'b01, 6'h21, 5'd3, 32'hDEAD_BEEF, 1'b0);
        run_op("t4_op00", 2'b00, 6'h30, 5'd3, 32'hDEAD_BEEF, 1'b0);
        run_op("ro_read_x0", 2'b10, 6'h27, 5'd9, 32'h0, 1'b1);
        run_op("ro_hi_edge", 2'b01, 6'h28, 5'd0, 32'h0BAD_F00D, 1'b0);

        // Reset during WCSR: outputs drop immediately, the rd write never happens
        preload(6'h05, 32'h0000_0011);
        preload(6'h30, 32'h0000_00AA);
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'b01; req_csr = 6'h30; req_rd = 5'd5;
        req_src = 32'h55; req_src_x0 = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t5_wcsr_wen", 32'(rd_wen), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_wen", 32'(rd_wen), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_waddr", 32'(rd_waddr), 32'd0);
        check("t5_wdata", rd_wdata, 32'd0);
        check("t5_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op("t5_after", 2'b10, 6'h31, 5'd6, 32'h0000_0100, 1'b0);
        check("t5_first_try", last_tries, 0);
        check("t5_rd_dropped", regs[6'h05], 32'h0000_0011);

        // Back-to-back with req_valid held high
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'b01; req_csr = 6'h33; req_rd = 5'd0;
        req_src = $urandom; req_src_x0 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check("t6_ready", 32'(req_ready), 32'((c % 5) == 0));
            if (req_ready) acc_at.push_back(c);
            @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("t6_accepts", acc_at.size(), 4);

        // Randomised ops against the rule model
        for (int n = 0; n < 24; n++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_csr = 6'($urandom_range(32, 63));
            r_rd  = 5'($urandom_range(0, 31));
            r_x0  = ($urandom_range(0, 3) == 0);
            r_src = r_x0 ? 32'h0 : $urandom;
            if (n % 3 == 0) preload(r_csr, $urandom);
            run_op("rand", r_op, r_csr, r_rd, r_src, r_x0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
